// File: rtl/sd_arb_pkg.sv
// sd_arb_pkg -- shared types and constants for the two-port SD sector arbiter.
//   state_t      : arbiter FSM states
//   port_idx_t   : requester index (0 or 1)
//   SECTOR_BYTES : bytes in one SD sector transfer
package sd_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef logic [0:0] port_idx_t;

    localparam int SECTOR_BYTES = 512;

endpackage

// File: rtl/sd_arbiter_if.sv
// sd_arbiter_if -- host-side SD sector bus between the arbiter and the SD host.
//   sd_lba/sd_rd/sd_wr : sector address and read/write request (arbiter -> host)
//   sd_ack             : host acknowledge, held for the whole transfer (SPI domain)
//   sd_dout/_strobe    : read byte and its strobe (host -> arbiter, SPI domain)
//   sd_din/_strobe     : write byte (arbiter -> host) and consume strobe (SPI domain)
// Modports: master = arbiter side, slave = SD host side.
interface sd_arbiter_if;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic [7:0]  sd_dout;
    logic        sd_dout_strobe;
    logic [7:0]  sd_din;
    logic        sd_din_strobe;

    modport master (
        output sd_lba, sd_rd, sd_wr, sd_din,
        input  sd_ack, sd_dout, sd_dout_strobe, sd_din_strobe
    );

    modport slave (
        input  sd_lba, sd_rd, sd_wr, sd_din,
        output sd_ack, sd_dout, sd_dout_strobe, sd_din_strobe
    );
endinterface

// File: rtl/sd_sync.sv
// sd_sync -- two-flop synchronizer for one asynchronous level, with edge detect.
//   clk_sys  : destination clock
//   reset    : synchronous active-high reset
//   async_in : level from the SPI clock domain
//   rise     : one-cycle pulse when the synchronized level goes 0 -> 1
//   fall     : one-cycle pulse when the synchronized level goes 1 -> 0
module sd_sync (
    input  logic clk_sys,
    input  logic reset,
    input  logic async_in,
    output logic rise,
    output logic fall
);
    logic sync_p0, sync_p1, sync_p2;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
        end else begin
            // p0/p1 resolve metastability; p2 holds the previous stable level
            sync_p0 <= async_in;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    assign rise = sync_p1 & ~sync_p2;
    assign fall = ~sync_p1 & sync_p2;
endmodule

// File: rtl/sd_arbiter.sv
// sd_arbiter -- round-robin arbiter giving two requesters access to one SD host.
//   clk_sys, reset          : system clock, synchronous active-high reset
//   lba_n, rd_n, wr_n       : sector address and read/write request of requester n
//   ack_n                   : requester n owns the current transfer
//   dout_n, dout_strobe_n   : read byte and its one-cycle valid for requester n
//   din_n, din_strobe_n     : write byte from requester n and its one-cycle consume
//   host                    : SD host bus (sd_arbiter_if.master)
//   err                     : one-cycle request-timeout pulse
// Build option: define SD_ARB_TIMEOUT_EN to abandon a request that the host has
// not acknowledged within TIMEOUT cycles; otherwise REQ waits forever, err = 0.
module sd_arbiter
    import sd_arb_pkg::*;
#(
    parameter logic [23:0] TIMEOUT = 24'd12000000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [31:0] lba_0,
    input  logic        rd_0,
    input  logic        wr_0,
    output logic        ack_0,
    output logic [7:0]  dout_0,
    output logic        dout_strobe_0,
    input  logic [7:0]  din_0,
    output logic        din_strobe_0,
    input  logic [31:0] lba_1,
    input  logic        rd_1,
    input  logic        wr_1,
    output logic        ack_1,
    output logic [7:0]  dout_1,
    output logic        dout_strobe_1,
    input  logic [7:0]  din_1,
    output logic        din_strobe_1,
    sd_arbiter_if.master host,
    output logic        err
);
    state_t      state, state_nxt;
    port_idx_t   grant, last_grant, gnt_sel;
    logic        dir_wr;
    logic [31:0] lba_q;
    logic [9:0]  byte_cnt;
    logic        req_0, req_1, any_req, sel_rd, sel_wr;
    logic        ack_rise, ack_fall, dout_rise, din_rise;
    logic        unused_dout_fall, unused_din_fall;
    logic        xfer_dout, xfer_din, byte_evt, last_byte, tmo_hit;

    sd_sync u_sync_ack  (.clk_sys, .reset, .async_in(host.sd_ack),
                         .rise(ack_rise),  .fall(ack_fall));
    sd_sync u_sync_dout (.clk_sys, .reset, .async_in(host.sd_dout_strobe),
                         .rise(dout_rise), .fall(unused_dout_fall));
    sd_sync u_sync_din  (.clk_sys, .reset, .async_in(host.sd_din_strobe),
                         .rise(din_rise),  .fall(unused_din_fall));

    assign req_0   = rd_0 | wr_0;
    assign req_1   = rd_1 | wr_1;
    assign any_req = req_0 | req_1;

    // On a tie the port that was not granted last wins.
    always_comb begin
        if (req_0 && req_1) gnt_sel = ~last_grant;
        else                gnt_sel = req_1;
    end

    assign sel_rd = gnt_sel[0] ? rd_1 : rd_0;
    assign sel_wr = gnt_sel[0] ? wr_1 : wr_0;

    assign xfer_dout = (state == ST_XFER) && dout_rise;
    assign xfer_din  = (state == ST_XFER) && din_rise;
    assign byte_evt  = xfer_dout || xfer_din;
    assign last_byte = (byte_cnt == 10'(SECTOR_BYTES - 1));

`ifdef SD_ARB_TIMEOUT_EN
    logic [23:0] tmo_cnt;

    always_ff @(posedge clk_sys) begin
        if (reset || state != ST_REQ) tmo_cnt <= '0;
        else                          tmo_cnt <= tmo_cnt + 24'd1;
    end

    assign tmo_hit = (state == ST_REQ) && !ack_rise && (tmo_cnt == TIMEOUT - 24'd1);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign tmo_hit        = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_sys) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (any_req) state_nxt = ST_REQ;
            ST_REQ: begin
                if (ack_rise)     state_nxt = ST_XFER;
                else if (tmo_hit) state_nxt = ST_IDLE;
            end
            ST_XFER: begin
                // Host dropping ack early ends a short transfer outright.
                if (ack_fall)                   state_nxt = ST_IDLE;
                else if (byte_evt && last_byte) state_nxt = ST_DONE;
            end
            ST_DONE: if (ack_fall) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        host.sd_rd = 1'b0;
        host.sd_wr = 1'b0;
        ack_0      = 1'b0;
        ack_1      = 1'b0;
        err        = 1'b0;
        case (state)
            ST_REQ: begin
                host.sd_rd = ~dir_wr;
                host.sd_wr = dir_wr;
                err        = tmo_hit;
            end
            ST_XFER, ST_DONE: begin
                ack_0 = ~grant[0];
                ack_1 = grant[0];
            end
            default: ;
        endcase
    end

    assign host.sd_lba = lba_q;
    assign host.sd_din = grant[0] ? din_1 : din_0;

    // Grant latch, byte counter and requester-side strobes/data
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            last_grant    <= 1'b1;   // pretend port 1 went last so port 0 wins first
            grant         <= 1'b0;
            dir_wr        <= 1'b0;
            lba_q         <= '0;
            byte_cnt      <= '0;
            dout_0        <= '0;
            dout_1        <= '0;
            dout_strobe_0 <= 1'b0;
            dout_strobe_1 <= 1'b0;
            din_strobe_0  <= 1'b0;
            din_strobe_1  <= 1'b0;
        end else begin
            dout_strobe_0 <= xfer_dout && !grant[0];
            dout_strobe_1 <= xfer_dout &&  grant[0];
            din_strobe_0  <= xfer_din  && !grant[0];
            din_strobe_1  <= xfer_din  &&  grant[0];

            if (state == ST_IDLE && any_req) begin
                grant      <= gnt_sel;
                last_grant <= gnt_sel;
                dir_wr     <= sel_wr && !sel_rd;   // rd+wr together counts as a read
                lba_q      <= gnt_sel[0] ? lba_1 : lba_0;
                byte_cnt   <= '0;
            end

            if (xfer_dout) begin
                if (grant[0]) dout_1 <= host.sd_dout;
                else          dout_0 <= host.sd_dout;
            end

            if (byte_evt) byte_cnt <= byte_cnt + 10'd1;
        end
    end
endmodule

// File: tb/tb_sd_arbiter.sv
// tb_sd_arbiter -- self-checking bench for sd_arbiter: arbitration vector table,
// directed sector read/write/reset sequences, and randomized transfers checked
// against a round-robin reference model.
`timescale 1ns/1ps
module tb_sd_arbiter;
    logic        clk_sys = 1'b0;
    logic        reset;
    logic [31:0] lba_0, lba_1;
    logic        rd_0, wr_0, rd_1, wr_1;
    logic        ack_0, ack_1;
    logic [7:0]  dout_0, dout_1, din_0, din_1;
    logic        dout_strobe_0, dout_strobe_1, din_strobe_0, din_strobe_1;
    logic        err;

    sd_arbiter_if sd_bus ();

    sd_arbiter #(.TIMEOUT(24'd1000)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .lba_0(lba_0), .rd_0(rd_0), .wr_0(wr_0), .ack_0(ack_0),
        .dout_0(dout_0), .dout_strobe_0(dout_strobe_0), .din_0(din_0), .din_strobe_0(din_strobe_0),
        .lba_1(lba_1), .rd_1(rd_1), .wr_1(wr_1), .ack_1(ack_1),
        .dout_1(dout_1), .dout_strobe_1(dout_strobe_1), .din_1(din_1), .din_strobe_1(din_strobe_1),
        .host(sd_bus), .err(err)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_err    = 0;

    // Monitor: everything the requesters see, recorded on the falling edge.
    logic [7:0] got0[$];
    logic [7:0] got1[$];
    int dinc0 = 0, dinc1 = 0, errc = 0, ack0c = 0, dual_ack = 0;

    always @(negedge clk_sys) begin
        if (dout_strobe_0) got0.push_back(dout_0);
        if (dout_strobe_1) got1.push_back(dout_1);
        if (din_strobe_0)  dinc0++;
        if (din_strobe_1)  dinc1++;
        if (err)           errc++;
        if (ack_0)         ack0c++;
        if (ack_0 && ack_1) dual_ack++;
    end

    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        {rd_0, wr_0, rd_1, wr_1} = 4'b0000;
        sd_bus.sd_ack = 1'b0;
        sd_bus.sd_dout_strobe = 1'b0;
        sd_bus.sd_din_strobe = 1'b0;
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
    endtask

    // Waits for the host request, then checks address and direction.
    task automatic serve_grant(input string tag, input bit is_wr, input logic [31:0] exp_lba);
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk_sys);
            ok = sd_bus.sd_rd | sd_bus.sd_wr;
        end
        chk({tag, "_req_up"}, 64'(ok), 64'd1);
        chk({tag, "_lba"}, 64'(sd_bus.sd_lba), 64'(exp_lba));
        chk({tag, "_sd_rd"}, 64'(sd_bus.sd_rd), 64'(!is_wr));
        chk({tag, "_sd_wr"}, 64'(sd_bus.sd_wr), 64'(is_wr));
        chk({tag, "_no_ack_yet"}, 64'(ack_0 | ack_1), 64'd0);
    endtask

    task automatic ack_up(input string tag, input bit port);
        bit ok = 1'b0;
        sd_bus.sd_ack = 1'b1;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk_sys);
            ok = port ? ack_1 : ack_0;
        end
        chk({tag, "_ack_up"}, 64'(ok), 64'd1);
        chk({tag, "_other_ack"}, 64'(port ? ack_0 : ack_1), 64'd0);
        chk({tag, "_req_dropped"}, 64'(sd_bus.sd_rd | sd_bus.sd_wr), 64'd0);
    endtask

    task automatic ack_down(input string tag, input bit port);
        bit ok = 1'b0;
        sd_bus.sd_ack = 1'b0;
        chk({tag, "_ack_hold"}, 64'(port ? ack_1 : ack_0), 64'd1);
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk_sys);
            ok = !(ack_0 | ack_1);
        end
        chk({tag, "_ack_down"}, 64'(ok), 64'd1);
        @(negedge clk_sys);
    endtask

    task automatic pulse_dout(input logic [7:0] b);
        sd_bus.sd_dout = b;
        sd_bus.sd_dout_strobe = 1'b1;
        @(negedge clk_sys);
        sd_bus.sd_dout_strobe = 1'b0;
        repeat (3) @(negedge clk_sys);
    endtask

    task automatic read_bytes(input int n, input bit seq);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = seq ? 8'(i) : 8'($urandom);
            exp_q.push_back(b);
            pulse_dout(b);
        end
    endtask

    task automatic cmp_rx(input string tag, input bit port, input int b0, input int b1, input int n);
        int own, other, bad;
        logic [7:0] g;
        own   = port ? got1.size() - b1 : got0.size() - b0;
        other = port ? got0.size() - b0 : got1.size() - b1;
        chk({tag, "_rx_cnt"}, 64'(own), 64'(n));
        chk({tag, "_other_rx_cnt"}, 64'(other), 64'd0);
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (i >= own) bad++;
            else begin
                g = port ? got1[b1 + i] : got0[b0 + i];
                if (g !== exp_q[i]) bad++;
            end
        end
        chk({tag, "_rx_data_bad"}, 64'(bad), 64'd0);
        exp_q.delete();
    endtask

    task automatic write_bytes(input string tag, input bit port, input int n);
        int c0, c1, bad;
        logic [7:0] d;
        c0 = dinc0; c1 = dinc1; bad = 0;
        for (int i = 0; i < n; i++) begin
            d = 8'($urandom);
            if (port) begin din_1 = d; din_0 = ~d; end
            else      begin din_0 = d; din_1 = ~d; end
            sd_bus.sd_din_strobe = 1'b1;
            @(negedge clk_sys);
            if (sd_bus.sd_din !== d) bad++;
            sd_bus.sd_din_strobe = 1'b0;
            repeat (3) @(negedge clk_sys);
        end
        chk({tag, "_din_cnt"}, 64'(port ? dinc1 - c1 : dinc0 - c0), 64'(n));
        chk({tag, "_other_din_cnt"}, 64'(port ? dinc0 - c0 : dinc1 - c1), 64'd0);
        chk({tag, "_sd_din_bad"}, 64'(bad), 64'd0);
    endtask

    typedef struct {
        bit rd0, wr0, rd1, wr1;
        bit port;
        bit is_wr;
    } arb_vec_t;

    arb_vec_t vec[8];
    int b0, b1, n, err_at, e0, a0;
    bit model_last, win, wdir, q0, q1;
    logic [3:0] rq;
    logic [31:0] la, lb;
    string tag;

    initial begin
        // {rd0, wr0, rd1, wr1, granted port, write} applied in order from reset
        vec[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vec[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vec[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vec[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vec[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vec[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

        reset = 1'b1;
        {rd_0, wr_0, rd_1, wr_1} = 4'b0000;
        lba_0 = 32'h0; lba_1 = 32'h0; din_0 = 8'h0; din_1 = 8'h0;
        sd_bus.sd_ack = 1'b0; sd_bus.sd_dout = 8'h0;
        sd_bus.sd_dout_strobe = 1'b0; sd_bus.sd_din_strobe = 1'b0;
        repeat (3) @(negedge clk_sys);

        chk("rst_sd_rd", 64'(sd_bus.sd_rd), 64'd0);
        chk("rst_sd_wr", 64'(sd_bus.sd_wr), 64'd0);
        chk("rst_acks", 64'({ack_0, ack_1}), 64'd0);
        chk("rst_strobes", 64'({dout_strobe_0, dout_strobe_1, din_strobe_0, din_strobe_1}), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_lba", 64'(sd_bus.sd_lba), 64'd0);
        chk("rst_douts", 64'({dout_0, dout_1}), 64'd0);
        reset = 1'b0;
        @(negedge clk_sys);

        // Arbitration table
        for (int i = 0; i < 8; i++) begin
            tag = $sformatf("arb%0d", i);
            lba_0 = 32'hA000_0000 + 32'(i);
            lba_1 = 32'hB000_0000 + 32'(i);
            {rd_0, wr_0, rd_1, wr_1} = {vec[i].rd0, vec[i].wr0, vec[i].rd1, vec[i].wr1};
            serve_grant(tag, vec[i].is_wr, vec[i].port ? lba_1 : lba_0);
            {rd_0, wr_0, rd_1, wr_1} = 4'b0000;
            ack_up(tag, vec[i].port);
            ack_down(tag, vec[i].port);
        end

        // Full sector read on port 0, then a stray strobe while DONE
        do_reset();
        lba_0 = 32'h0000_0123; rd_0 = 1'b1;
        serve_grant("rd512", 1'b0, 32'h0000_0123);
        rd_0 = 1'b0;
        ack_up("rd512", 1'b0);
        b0 = got0.size(); b1 = got1.size();
        read_bytes(512, 1'b1);
        cmp_rx("rd512", 1'b0, b0, b1, 512);
        pulse_dout(8'hAA);
        chk("done_extra_strobe", 64'(got0.size() - b0), 64'd512);
        chk("done_ack_held", 64'(ack_0), 64'd1);
        ack_down("rd512", 1'b0);

        // Simultaneous rd_0 / wr_1 after reset: port 0 read first, then port 1 write sector
        do_reset();
        lba_0 = 32'h0000_1000; lba_1 = 32'h0000_2000;
        rd_0 = 1'b1; wr_1 = 1'b1;
        serve_grant("both_p0", 1'b0, 32'h0000_1000);
        rd_0 = 1'b0;
        ack_up("both_p0", 1'b0);
        b0 = got0.size(); b1 = got1.size();
        read_bytes(8, 1'b0);
        cmp_rx("both_p0", 1'b0, b0, b1, 8);
        ack_down("both_p0", 1'b0);
        serve_grant("both_p1", 1'b1, 32'h0000_2000);
        wr_1 = 1'b0;
        ack_up("both_p1", 1'b1);
        write_bytes("both_p1", 1'b1, 512);
        chk("both_p1_done_ack", 64'(ack_1), 64'd1);
        ack_down("both_p1", 1'b1);

        // Reset after 100 read bytes with byte 101 in the synchronizer
        do_reset();
        lba_0 = 32'h0000_0055; rd_0 = 1'b1;
        serve_grant("rst_mid", 1'b0, 32'h0000_0055);
        rd_0 = 1'b0;
        ack_up("rst_mid", 1'b0);
        b0 = got0.size(); b1 = got1.size();
        read_bytes(100, 1'b1);
        cmp_rx("rst_mid", 1'b0, b0, b1, 100);
        sd_bus.sd_dout = 8'h64; sd_bus.sd_dout_strobe = 1'b1;
        @(negedge clk_sys);
        sd_bus.sd_dout_strobe = 1'b0; sd_bus.sd_ack = 1'b0; reset = 1'b1;
        @(negedge clk_sys);
        chk("rst_mid_rdwr", 64'({sd_bus.sd_rd, sd_bus.sd_wr}), 64'd0);
        chk("rst_mid_acks", 64'({ack_0, ack_1}), 64'd0);
        chk("rst_mid_strobes", 64'({dout_strobe_0, dout_strobe_1, din_strobe_0, din_strobe_1}), 64'd0);
        chk("rst_mid_lba", 64'(sd_bus.sd_lba), 64'd0);
        chk("rst_mid_douts", 64'({dout_0, dout_1}), 64'd0);
        chk("rst_mid_err", 64'(err), 64'd0);
        reset = 1'b0;
        repeat (6) @(negedge clk_sys);
        chk("rst_mid_no_more_strobes", 64'(got0.size() - b0), 64'd100);
        lba_1 = 32'h0000_0077; wr_1 = 1'b1;
        serve_grant("after_rst", 1'b1, 32'h0000_0077);
        wr_1 = 1'b0;
        ack_up("after_rst", 1'b1);
        write_bytes("after_rst", 1'b1, 4);
        ack_down("after_rst", 1'b1);

        // Randomized transfers against the round-robin model
        do_reset();
        model_last = 1'b1;
        for (int t = 0; t < 10; t++) begin
            tag = $sformatf("rnd%0d", t);
            rq = 4'($urandom_range(1, 15));
            q0 = rq[3] | rq[2];
            q1 = rq[1] | rq[0];
            win  = (q0 && q1) ? !model_last : q1;
            wdir = win ? (rq[0] && !rq[1]) : (rq[2] && !rq[3]);
            la = $urandom; lb = $urandom;
            lba_0 = la; lba_1 = lb;
            {rd_0, wr_0, rd_1, wr_1} = rq;
            serve_grant(tag, wdir, win ? lb : la);
            {rd_0, wr_0, rd_1, wr_1} = 4'b0000;
            ack_up(tag, win);
            n = int'($urandom_range(1, 12));
            if (wdir) write_bytes(tag, win, n);
            else begin
                b0 = got0.size(); b1 = got1.size();
                read_bytes(n, 1'b0);
                cmp_rx(tag, win, b0, b1, n);
            end
            ack_down(tag, win);
            model_last = win;
        end

`ifdef SD_ARB_TIMEOUT_EN
        do_reset();
        e0 = errc; a0 = ack0c; err_at = 0;
        rd_0 = 1'b1;
        for (int i = 1; i <= 1100; i++) begin
            @(negedge clk_sys);
            if (i == 1) rd_0 = 1'b0;
            if (err && err_at == 0) err_at = i;
        end
        chk("tmo_err_cycle", 64'(err_at), 64'd1000);
        chk("tmo_err_count", 64'(errc - e0), 64'd1);
        chk("tmo_sd_rd", 64'(sd_bus.sd_rd), 64'd0);
        chk("tmo_no_ack", 64'(ack0c - a0), 64'd0);
`else
        chk("err_never", 64'(errc), 64'd0);
`endif
        chk("never_both_acks", 64'(dual_ack), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish before 500us");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/sd_arbiter.md
SD_ARBITER -- requirements
Module: sd_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT, 24'd12000000, clk_sys cycles allowed from request to host ack (used only with SD_ARB_TIMEOUT_EN).
REQ-002 SHALL have port: clk_sys  in  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports per requester n in {0,1}: lba_n  in  32  sector address; rd_n  in  1  read request; wr_n  in  1  write request; ack_n  out  1  transfer owned by requester n.
REQ-005 SHALL have ports per requester n: dout_n  out  8  read data; dout_strobe_n  out  1  one-cycle read-byte valid; din_n  in  8  write data; din_strobe_n  out  1  one-cycle write-byte consumed.
REQ-006 SHALL have host-side ports: sd_lba  out  32; sd_rd  out  1; sd_wr  out  1; sd_ack  in  1; sd_dout  in  8; sd_dout_strobe  in  1; sd_din  out  8; sd_din_strobe  in  1. The sd_ack and strobe inputs are in the SPI clock domain.
REQ-007 SHALL have port: err  out  1  one-cycle timeout pulse; constant 0 without SD_ARB_TIMEOUT_EN.

Function
REQ-008 SHALL pass sd_ack, sd_dout_strobe and sd_din_strobe through a 2-flop synchronizer and use their rising-edge detects.
REQ-009 SHALL implement the states IDLE, REQ, XFER and DONE.
REQ-010 IDLE: when any rd_n or wr_n is high, SHALL grant one requester and latch its lba and direction, then move to REQ.
REQ-011 Simultaneous requests SHALL be arbitrated round-robin: the port not granted last wins; the first arbitration after reset favours port 0.
REQ-012 If one port asserts rd and wr together, SHALL treat it as a read.
REQ-013 REQ: SHALL drive sd_lba with the latched value and assert sd_rd or sd_wr. On a synchronized sd_ack rise, SHALL deassert sd_rd/sd_wr, assert ack_g for the granted port and go to XFER.
REQ-014 XFER: each sd_dout_strobe edge SHALL register sd_dout into dout_g and pulse dout_strobe_g for 1 cycle, 2-3 cycles after the host strobe.
REQ-015 XFER: sd_din SHALL continuously mux din_g; each sd_din_strobe edge SHALL pulse din_strobe_g for 1 cycle.
REQ-016 SHALL count transferred bytes with a 10-bit counter; at 512 SHALL go to DONE. Extra strobes in DONE SHALL be ignored.
REQ-017 DONE: on a synchronized sd_ack fall, SHALL deassert ack_g and return to IDLE. If sd_ack falls in XFER before 512 bytes, SHALL go directly to IDLE.
REQ-018 A requester dropping rd/wr after grant SHALL NOT abort the transfer; the grant holds until IDLE.
REQ-019 A non-granted port's ack, dout_strobe and din_strobe SHALL stay 0; its dout SHALL hold its last value.

Reset
REQ-020 On reset, the state SHALL be IDLE; sd_rd, sd_wr, all ack_n, all strobes and err SHALL be 0; sd_lba, dout_n and the byte counter SHALL be 0; the last grant SHALL favour port 0.
REQ-021 Reset mid-transfer SHALL abandon the transfer without emitting further strobes.

Configuration
REQ-022 With SD_ARB_TIMEOUT_EN defined, a cycle counter SHALL run in REQ; on reaching TIMEOUT it SHALL pulse err, deassert sd_rd/sd_wr and return to IDLE without asserting ack.
REQ-023 Without SD_ARB_TIMEOUT_EN, REQ SHALL wait indefinitely, no timeout counter SHALL exist and err SHALL be tied to 0.

Structure
REQ-024 Package sd_arb_pkg SHALL hold the state enum, SECTOR_BYTES=512 and the port-index type.
REQ-025 Sub-module sd_sync SHALL implement the 2-flop synchronizer plus rise/fall detect, instantiated once per async input.

Verification
REQ-026 rd_0=1, lba_0=32'h00000123 -> sd_rd=1 and sd_lba=32'h123; host acks and sends 512 bytes 0x00..0xFF repeated -> 512 dout_strobe_0 pulses with matching data; ack_0 falls after sd_ack falls.
REQ-027 rd_0 and wr_1 rise in the same cycle after reset -> port 0 is served first (read), then port 1 with sd_wr=1; 512 din_strobe_1 pulses; sd_din follows din_1.
REQ-028 Port 1 served last, then both request -> port 0 is granted; the next simultaneous request grants port 1.
REQ-029 reset asserted after 100 bytes of a read -> no further dout_strobe; all outputs 0 the next cycle; the next request starts cleanly.
REQ-030 With SD_ARB_TIMEOUT_EN and TIMEOUT=1000, no sd_ack -> err pulses exactly once at cycle 1000; sd_rd=0; ack_0 is never asserted.
